// File: rtl/config_frame_pkg.sv
// Shared constants and state type for the configuration frame writer.
package config_frame_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam int DESYNC_BIT    = 20;
    localparam int COLUMN_MSB    = 31;
    localparam int COLUMN_LSB    = 24;
    localparam int FRAME_IDX_MSB = 4;
    localparam int FRAME_IDX_LSB = 0;
    localparam int FRAME_IDX_W   = FRAME_IDX_MSB - FRAME_IDX_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDRESS,
        ST_DATA,
        ST_STROBE
    } frame_state_t;

endpackage

// File: rtl/frame_select_decoder.sv
// Binary frame index to one-hot strobe vector, flagging indices past the column depth.
module frame_select_decoder
    import config_frame_pkg::*;
#(
    parameter int unsigned MAX_FRAMES_PER_COL = 20
) (
    input  logic [FRAME_IDX_W-1:0]        frame_index,
    output logic [MAX_FRAMES_PER_COL-1:0] one_hot,
    output logic                          out_of_range
);

    always_comb begin
        one_hot = '0;
        for (int unsigned i = 0; i < MAX_FRAMES_PER_COL; i++) begin
            one_hot[i] = (32'(frame_index) == i);
        end
        out_of_range = (32'(frame_index) >= MAX_FRAMES_PER_COL);
    end

endmodule

// File: rtl/config_frame_writer.sv
// Collects sync/address/data word stream into frames and pulses a one-hot frame strobe.
module config_frame_writer
    import config_frame_pkg::*;
#(
    parameter int unsigned NUMBER_OF_ROWS      = 16,
    parameter int unsigned MAX_FRAMES_PER_COL  = 20,
    parameter int unsigned COLUMN_SELECT_WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [31:0]                    write_data_i,
    input  logic                           word_write_strobe_i,
    output logic [32*NUMBER_OF_ROWS-1:0]   frame_data_o,
    output logic [MAX_FRAMES_PER_COL-1:0]  frame_strobe_o,
    output logic [COLUMN_SELECT_WIDTH-1:0] column_select_o,
    output logic                           busy_o,
    output logic                           configured_o,
    output logic                           error_o
);

    localparam int unsigned FRAME_W = 32 * NUMBER_OF_ROWS;
    localparam int unsigned ROW_W   = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUMBER_OF_ROWS - 1);

    frame_state_t                  state, state_next;
    logic [ROW_W-1:0]              row_cnt;
    logic [FRAME_IDX_W-1:0]        frame_idx;
    logic [MAX_FRAMES_PER_COL-1:0] decoded_strobe;
    logic                          decoded_oor;

    logic latch_addr;
    logic shift_word;
    logic last_word;
    logic set_configured;
    logic clear_flags;

    frame_select_decoder #(
        .MAX_FRAMES_PER_COL(MAX_FRAMES_PER_COL)
    ) u_decoder (
        .frame_index (frame_idx),
        .one_hot     (decoded_strobe),
        .out_of_range(decoded_oor)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // STROBE falls back to ADDRESS but still accepts a word under the ADDRESS rules.
    always_comb begin
        state_next     = state;
        latch_addr     = 1'b0;
        shift_word     = 1'b0;
        last_word      = 1'b0;
        set_configured = 1'b0;
        clear_flags    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (word_write_strobe_i && write_data_i == SYNC_WORD) begin
                    state_next  = ST_ADDRESS;
                    clear_flags = 1'b1;
                end
            end
            ST_ADDRESS, ST_STROBE: begin
                state_next = ST_ADDRESS;
                if (word_write_strobe_i && write_data_i != SYNC_WORD) begin
                    if (write_data_i[DESYNC_BIT]) begin
                        state_next     = ST_IDLE;
                        set_configured = 1'b1;
                    end else begin
                        state_next = ST_DATA;
                        latch_addr = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (word_write_strobe_i) begin
                    shift_word = 1'b1;
                    if (row_cnt == LAST_ROW) begin
                        last_word  = 1'b1;
                        state_next = ST_STROBE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            row_cnt         <= '0;
            frame_idx       <= '0;
            frame_data_o    <= '0;
            frame_strobe_o  <= '0;
            column_select_o <= '0;
            busy_o          <= 1'b0;
            configured_o    <= 1'b0;
            error_o         <= 1'b0;
        end else begin
            busy_o         <= (state_next != ST_IDLE);
            frame_strobe_o <= last_word ? decoded_strobe : '0;

            if (latch_addr) begin
                row_cnt         <= '0;
                frame_idx       <= write_data_i[FRAME_IDX_MSB:FRAME_IDX_LSB];
                column_select_o <= COLUMN_SELECT_WIDTH'(write_data_i[COLUMN_MSB:COLUMN_LSB]);
            end

            if (shift_word) begin
                frame_data_o <= (frame_data_o << 32) | FRAME_W'(write_data_i);
                row_cnt      <= last_word ? '0 : row_cnt + ROW_W'(1);
            end

            if (clear_flags) begin
                configured_o <= 1'b0;
                error_o      <= 1'b0;
            end else begin
                if (set_configured) begin
                    configured_o <= 1'b1;
                end
                if (last_word && decoded_oor) begin
                    error_o <= 1'b1;
                end
            end
        end
    end

endmodule
